// File: rtl/program_loader.sv
// rtl/program_loader.sv - length/payload/checksum frame writer that fills CPU memory and gates CPU reset
module program_loader #(
    parameter int ADDR_WIDTH     = 5,
    parameter int DATA_WIDTH     = 8,
    parameter int MEM_DEPTH      = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  mem_write_en,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  cpu_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_SUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [GW-1:0]         GAP_LAST = GW'(TIMEOUT_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0] MAX_LEN  = DATA_WIDTH'(MEM_DEPTH);

    state_t                state;
    state_t                next_state;
    logic [GW-1:0]         gap;
    logic [CW-1:0]         cnt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] sum;
    logic                  xfer;
    logic                  timeout_hit;
    logic                  len_bad;
    logic                  next_active;

    // in_ready is registered, so a transfer is decided entirely by the current state
    assign xfer        = in_valid && in_ready;
    // a transfer on the limit cycle wins over the timeout
    assign timeout_hit = !xfer && (gap == GAP_LAST);
    assign len_bad     = (in_data == '0) || (in_data > MAX_LEN);
    assign next_active = (next_state == S_LEN) || (next_state == S_DATA) || (next_state == S_SUM);

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // next-state decode
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (start) next_state = S_LEN;
            S_LEN: begin
                if (xfer)             next_state = len_bad ? S_ERR : S_DATA;
                else if (timeout_hit) next_state = S_ERR;
            end
            S_DATA: begin
                if (xfer)             next_state = (cnt == CW'(1)) ? S_SUM : S_DATA;
                else if (timeout_hit) next_state = S_ERR;
            end
            S_SUM: begin
                if (xfer)             next_state = (in_data == sum) ? S_DONE : S_ERR;
                else if (timeout_hit) next_state = S_ERR;
            end
            S_DONE, S_ERR: if (start) next_state = S_LEN;
            default: next_state = S_IDLE;
        endcase
    end

    // datapath, memory write port and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready     <= 1'b0;
            mem_write_en <= 1'b0;
            mem_address  <= '0;
            mem_data     <= '0;
            cpu_rst      <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            gap          <= '0;
            cnt          <= '0;
            addr         <= '0;
            sum          <= '0;
        end else begin
            mem_write_en <= 1'b0;
            in_ready     <= next_active;
            busy         <= next_active;
            done         <= (next_state == S_DONE);
            error        <= (next_state == S_ERR);
            cpu_rst      <= (next_state != S_DONE);

            if (xfer || (next_state == S_LEN && state != S_LEN))
                gap <= '0;
            else if (state == S_LEN || state == S_DATA || state == S_SUM)
                gap <= gap + GW'(1);

            if (xfer && state == S_LEN) begin
                cnt  <= in_data[CW-1:0];
                addr <= '0;
                sum  <= '0;
            end

            if (xfer && state == S_DATA) begin
                mem_write_en <= 1'b1;
                mem_address  <= addr;
                mem_data     <= in_data;
                addr         <= addr + ADDR_WIDTH'(1);
                sum          <= sum + in_data;
                cnt          <= cnt - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized frame bench for program_loader against a frame-level model
module tb_program_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       mem_write_en;
    logic [4:0] mem_address;
    logic [7:0] mem_data;
    logic       cpu_rst;
    logic       busy;
    logic       done;
    logic       error;

    program_loader #(
        .ADDR_WIDTH(5), .DATA_WIDTH(8), .MEM_DEPTH(32), .TIMEOUT_CYCLES(255)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_write_en(mem_write_en), .mem_address(mem_address),
        .mem_data(mem_data), .cpu_rst(cpu_rst), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] wr_a[$];
    logic [7:0] wr_d[$];

    always @(negedge clk) begin
        if (mem_write_en === 1'b1) begin
            wr_a.push_back({3'b000, mem_address});
            wr_d.push_back(mem_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int idle);
        int t;
        repeat (idle) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("ready_wait_expired", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic check_writes(input string tag, input logic [7:0] ea[$], input logic [7:0] ed[$]);
        check({tag, "_nwrites"}, wr_a.size(), ea.size());
        for (int i = 0; i < ea.size() && i < wr_a.size(); i++) begin
            check({tag, "_addr"}, wr_a[i], ea[i]);
            check({tag, "_data"}, wr_d[i], ed[i]);
        end
    endtask

    // frame-level reference: length rule, in-order writes, mod-256 checksum
    task automatic run_frame(input string tag, input logic [7:0] fr[$], input int maxgap);
        logic [7:0] ea[$];
        logic [7:0] ed[$];
        int         len;
        int         s;
        bit         exp_done;
        len = fr[0];
        wr_a.delete();
        wr_d.delete();
        pulse_start();
        send_byte(fr[0], $urandom_range(0, maxgap));
        if (len == 0 || len > 32) begin
            exp_done = 1'b0;
        end else begin
            s = 0;
            for (int i = 0; i < len; i++) begin
                ea.push_back(8'(i));
                ed.push_back(fr[1 + i]);
                s = (s + fr[1 + i]) % 256;
                send_byte(fr[1 + i], $urandom_range(0, maxgap));
            end
            send_byte(fr[len + 1], $urandom_range(0, maxgap));
            exp_done = (fr[len + 1] == 8'(s));
        end
        repeat (2) @(negedge clk);
        check({tag, "_done"}, done, exp_done);
        check({tag, "_error"}, error, !exp_done);
        check({tag, "_cpu_rst"}, cpu_rst, !exp_done);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_in_ready"}, in_ready, 1'b0);
        check_writes(tag, ea, ed);
    endtask

    initial begin
        logic [7:0] fr[$];
        logic [7:0] ea[$];
        logic [7:0] ed[$];
        int         len;
        int         s;

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_cpu_rst", cpu_rst, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_wen", mem_write_en, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", in_ready, 1'b0);

        fr = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
        run_frame("t1_good", fr, 2);
        fr = '{8'h02, 8'hAA, 8'hBB, 8'h00};
        run_frame("t2_badsum", fr, 2);
        fr = '{8'h00};
        run_frame("t3_len0", fr, 0);
        fr = '{8'h21};
        run_frame("t3_len33", fr, 0);
        fr = '{8'h20};
        for (int i = 0; i < 32; i++) fr.push_back(8'h01);
        fr.push_back(8'h20);
        run_frame("t4_full", fr, 1);

        // timeout: two bytes accepted, then the stream goes quiet
        wr_a.delete(); wr_d.delete();
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'hAA, 0);
        repeat (254) @(negedge clk);
        check("t5_err_early", error, 1'b0);
        check("t5_busy_early", busy, 1'b1);
        @(negedge clk);
        check("t5_err", error, 1'b1);
        check("t5_cpu_rst", cpu_rst, 1'b1);
        check("t5_busy", busy, 1'b0);
        ea = '{8'h00}; ed = '{8'hAA};
        check_writes("t5", ea, ed);

        // reset in the same cycle as a data transfer drops that write
        wr_a.delete(); wr_d.delete();
        pulse_start();
        send_byte(8'h03, 0);
        send_byte(8'h11, 0);
        in_valid = 1'b1; in_data = 8'h22; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        check("t6_busy", busy, 1'b0);
        check("t6_cpu_rst", cpu_rst, 1'b1);
        check("t6_ready", in_ready, 1'b0);
        check("t6_wen", mem_write_en, 1'b0);
        check("t6_error", error, 1'b0);
        repeat (5) @(negedge clk);
        ea = '{8'h00}; ed = '{8'h11};
        check_writes("t6", ea, ed);

        fr = '{8'h01, 8'h5A, 8'h5A};
        run_frame("t6_good", fr, 0);
        pulse_start();
        check("t6_restart_cpu_rst", cpu_rst, 1'b1);
        check("t6_restart_done", done, 1'b0);
        check("t6_restart_busy", busy, 1'b1);
        send_byte(8'h01, 0);
        send_byte(8'h07, 0);
        send_byte(8'h07, 0);
        @(negedge clk);
        check("t6_refill_done", done, 1'b1);

        for (int n = 0; n < 25; n++) begin
            fr.delete();
            len = $urandom_range(0, 34);
            fr.push_back(8'(len));
            s = 0;
            for (int i = 0; i < len; i++) begin
                fr.push_back(8'($urandom_range(0, 255)));
                s = s + fr[i + 1];
            end
            if ($urandom_range(0, 3) == 0) s = s + 1 + $urandom_range(0, 254);
            fr.push_back(8'(s % 256));
            run_frame($sformatf("rnd%0d", n), fr, 3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
